// File: rtl/load_unit_ctrl.sv
// Single-outstanding RISC-V load sequencer: EA compute, word read request, response wait, lane extract/extend, writeback.
// Optional macro MISALIGN_TRAP_EN: misaligned LH/LHU/LW abort at accept with an err pulse instead of issuing.
module load_unit_ctrl #(
    parameter int XLEN        = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_base,
    input  logic [11:0]     ld_imm,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_control,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            err
);

    localparam int CNT_W = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LW  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [XLEN-1:0]  ea_q;
    logic [4:0]       rd_q;
    logic [2:0]       ctrl_q;
    logic [XLEN-1:0]  data_q;

    logic signed [11:0]     imm_s;
    logic signed [XLEN-1:0] imm_ext;
    logic [XLEN-1:0]        ea_in;
    logic                   accept;
    logic                   misalign;

    // Lane select and sign/zero extension of the returned word.
    function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] word,
                                                     input logic [1:0]      lane,
                                                     input logic [2:0]      ctrl);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (ctrl)
            LD_LH:   extract_load = {{(XLEN-16){h[15]}}, h};
            LD_LW:   extract_load = word;
            LD_LBU:  extract_load = {{(XLEN-8){1'b0}}, b};
            LD_LHU:  extract_load = {{(XLEN-16){1'b0}}, h};
            default: extract_load = {{(XLEN-8){b[7]}}, b};
        endcase
    endfunction

    assign imm_s   = ld_imm;
    assign imm_ext = {{(XLEN-12){imm_s[11]}}, imm_s};
    assign ea_in   = ld_base + imm_ext;
    assign accept  = ld_valid && (state_q == S_IDLE);

`ifdef MISALIGN_TRAP_EN
    assign misalign = (((ld_control == LD_LH) || (ld_control == LD_LHU)) && ea_in[0]) ||
                      ((ld_control == LD_LW) && (ea_in[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misalign) err_d = 1'b1;
                    else          state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the final allowed cycle takes priority over the abort.
                if (mem_rsp_valid) begin
                    state_d = S_WB;
                end else if ((RSP_TIMEOUT != 0) && (cnt_d == CNT_W'(RSP_TIMEOUT))) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Datapath registers carry no reset; outputs are gated by state instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            ea_q   <= ea_in;
            rd_q   <= ld_rd;
            ctrl_q <= ld_control;
        end
        if ((state_q == S_WAIT) && mem_rsp_valid) begin
            data_q <= mem_rsp_data;
        end
    end

    assign ld_ready      = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = (state_q == S_REQ) ? {ea_q[XLEN-1:2], 2'b00} : '0;
    assign wb_valid      = (state_q == S_WB) && (rd_q != 5'd0);
    assign wb_rd         = (state_q == S_WB) ? rd_q : 5'd0;
    assign wb_data       = (state_q == S_WB) ? extract_load(data_q, ea_q[1:0], ctrl_q) : '0;
    assign err           = err_q;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Directed bench for load_unit_ctrl: hand-computed loads, stalls, timeout, reset abort and rd=0 handling.
`timescale 1ns/1ps
module tb_load_unit_ctrl;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_base;
    logic [11:0] ld_imm;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_control;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    load_unit_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_base       (ld_base),
        .ld_imm        (ld_imm),
        .ld_rd         (ld_rd),
        .ld_control    (ld_control),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] base, input logic [11:0] imm,
                           input logic [4:0] rd, input logic [2:0] ctrl);
        ld_valid   = 1'b1;
        ld_base    = base;
        ld_imm     = imm;
        ld_rd      = rd;
        ld_control = ctrl;
    endtask

    // Full load with immediate request accept and a response in the first WAIT cycle.
    task automatic do_load(input string tag, input logic [31:0] base, input logic [11:0] imm,
                           input logic [4:0] rd, input logic [2:0] ctrl, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wb);
        present(base, imm, rd, ctrl);
        mem_req_ready = 1'b1;
        tick;
        ld_valid = 1'b0;
        check_eq({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd1);
        check_eq({tag, ".addr"}, mem_addr, exp_addr);
        check_eq({tag, ".ld_ready"}, {31'd0, ld_ready}, 32'd0);
        tick;
        check_eq({tag, ".wait_req"}, {31'd0, mem_req_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rdata;
        tick;
        mem_rsp_valid = 1'b0;
        check_eq({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, rd != 5'd0});
        check_eq({tag, ".busy_wb"}, {31'd0, busy}, 32'd1);
        if (rd != 5'd0) begin
            check_eq({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
            check_eq({tag, ".wb_data"}, wb_data, exp_wb);
        end
        tick;
        check_eq({tag, ".idle_ready"}, {31'd0, ld_ready}, 32'd1);
        check_eq({tag, ".wb_once"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [31:0] addr0;
        int          err_cnt;
        int          wbv_cnt;

        reset = 1'b1;
        ld_valid = 1'b0; ld_base = '0; ld_imm = '0; ld_rd = '0; ld_control = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick; tick;
        check_eq("rst.ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("rst.req_valid", {31'd0, mem_req_valid}, 32'd0);
        check_eq("rst.mem_addr", mem_addr, 32'd0);
        check_eq("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
        check_eq("rst.wb_data", wb_data, 32'd0);
        check_eq("rst.busy", {31'd0, busy}, 32'd0);
        check_eq("rst.err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        tick;

        do_load("lw",   32'h0000_1000, 12'd4,   5'd5, 3'd2, 32'hDEAD_BEEF, 32'h0000_1004, 32'hDEAD_BEEF);
        do_load("lb",   32'h0000_2000, 12'd3,   5'd6, 3'd0, 32'h8012_3456, 32'h0000_2000, 32'hFFFF_FF80);
        do_load("lbu",  32'h0000_2000, 12'd3,   5'd7, 3'd4, 32'h8012_3456, 32'h0000_2000, 32'h0000_0080);
        do_load("lh",   32'h0000_0010, 12'hFF2, 5'd8, 3'd1, 32'h8001_1234, 32'h0000_0000, 32'hFFFF_8001);
        do_load("lhu",  32'h0000_0010, 12'hFF2, 5'd9, 3'd5, 32'h8001_1234, 32'h0000_0000, 32'h0000_8001);
        do_load("lb0",  32'h0000_3000, 12'd0,   5'd1, 3'd0, 32'hAAAA_AA7F, 32'h0000_3000, 32'h0000_007F);
        do_load("lbdef",32'h0000_3000, 12'd1,   5'd2, 3'd3, 32'h0000_FE00, 32'h0000_3000, 32'hFFFF_FFFE);
        do_load("lhlo", 32'h0000_3000, 12'd0,   5'd3, 3'd1, 32'hFFFF_7FFF, 32'h0000_3000, 32'h0000_7FFF);
        do_load("wrap", 32'hFFFF_FFFC, 12'd8,   5'd4, 3'd2, 32'h1234_5678, 32'h0000_0004, 32'h1234_5678);
        do_load("rd0",  32'h0000_1000, 12'd0,   5'd0, 3'd2, 32'h5555_5555, 32'h0000_1000, 32'h0);
`ifndef MISALIGN_TRAP_EN
        do_load("lwmis", 32'h0000_1003, 12'd0,  5'd10, 3'd2, 32'hCAFE_F00D, 32'h0000_1000, 32'hCAFE_F00D);
        do_load("lhmis", 32'h0000_1000, 12'd3,  5'd11, 3'd1, 32'h9ABC_0000, 32'h0000_1000, 32'hFFFF_9ABC);
`else
        present(32'h0000_1000, 12'd2, 5'd12, 3'd2);
        tick;
        ld_valid = 1'b0;
        check_eq("trap.err", {31'd0, err}, 32'd1);
        check_eq("trap.req_valid", {31'd0, mem_req_valid}, 32'd0);
        check_eq("trap.busy", {31'd0, busy}, 32'd0);
        tick;
        check_eq("trap.err_once", {31'd0, err}, 32'd0);
        check_eq("trap.req_valid2", {31'd0, mem_req_valid}, 32'd0);
        check_eq("trap.wb_valid", {31'd0, wb_valid}, 32'd0);
`endif

        // Request stall: address and valid must hold while ready is low.
        present(32'h0000_4000, 12'h008, 5'd13, 3'd2);
        mem_req_ready = 1'b0;
        tick;
        ld_valid = 1'b0;
        addr0 = mem_addr;
        check_eq("stall.addr0", addr0, 32'h0000_4008);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall.req_valid", {31'd0, mem_req_valid}, 32'd1);
            check_eq("stall.addr", mem_addr, 32'h0000_4008);
            check_eq("stall.ld_ready", {31'd0, ld_ready}, 32'd0);
            tick;
        end
        mem_req_ready = 1'b1;
        tick;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_F00D;
        tick;
        mem_rsp_valid = 1'b0;
        check_eq("stall.wb_data", wb_data, 32'h0BAD_F00D);
        check_eq("stall.wb_valid", {31'd0, wb_valid}, 32'd1);
        tick;

        // Timeout: no response ever.
        present(32'h0000_5000, 12'd0, 5'd14, 3'd2);
        tick;
        ld_valid = 1'b0;
        tick;
        k = 0;
        wbv_cnt = 0;
        while (!err && k < 300) begin
            tick;
            k++;
            if (wb_valid) wbv_cnt++;
        end
        check_eq("tmo.cycles", k, 255);
        check_eq("tmo.no_wb", wbv_cnt, 0);
        check_eq("tmo.ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("tmo.busy", {31'd0, busy}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_1111;
        tick;
        mem_rsp_valid = 1'b0;
        check_eq("tmo.err_once", {31'd0, err}, 32'd0);
        check_eq("late_rsp.wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("late_rsp.busy", {31'd0, busy}, 32'd0);

        // Response in the final allowed WAIT cycle beats the abort.
        present(32'h0000_6000, 12'd0, 5'd15, 3'd2);
        tick;
        ld_valid = 1'b0;
        tick;
        err_cnt = 0;
        for (int i = 0; i < 254; i++) begin
            tick;
            if (err) err_cnt++;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_0000;
        tick;
        mem_rsp_valid = 1'b0;
        check_eq("race.err_none", err_cnt, 0);
        check_eq("race.wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("race.wb_data", wb_data, 32'h7777_0000);
        check_eq("race.err", {31'd0, err}, 32'd0);
        tick;
        check_eq("race.err_after", {31'd0, err}, 32'd0);

        // Reset while waiting, then a stale response.
        present(32'h0000_7000, 12'd0, 5'd16, 3'd2);
        tick;
        ld_valid = 1'b0;
        tick;
        tick;
        check_eq("rstw.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #2;
        check_eq("rstw.busy", {31'd0, busy}, 32'd0);
        check_eq("rstw.ld_ready", {31'd0, ld_ready}, 32'd1);
        tick;
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h2222_2222;
        tick;
        mem_rsp_valid = 1'b0;
        check_eq("rstw.wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rstw.busy_after", {31'd0, busy}, 32'd0);
        tick;
        check_eq("rstw.wb_valid2", {31'd0, wb_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
